// File: rtl/data_stack.sv
// data_stack: operand stack for the stack processor.
// The top two items live in the TOS/NOS registers. Deeper items live in a
// small RAM-style array that is used as a LIFO, indexed by the item count.
// One operation per clock: PUSH, POP, DUP, SWAP, OVER and optionally ADD/SUB.
// An operation that breaks a stack rule changes no state and sets a sticky
// OVERFLOW or UNDERFLOW flag instead.
// Optional feature macro: DATA_STACK_ARITH_EN enables ADD/SUB. Without it,
// codes 6 and 7 act as NOP and no adder is built.
module data_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             OP_VALID,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] PUSH_DATA,
  output logic [WIDTH-1:0] POP_DATA,
  output logic             POP_VALID,
  output logic [WIDTH-1:0] STACK_TOP_ITEM,
  output logic [31:0]      STACK_ITEM_COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  // Count needs to hold 0..DEPTH inclusive.
  localparam int CW    = $clog2(DEPTH + 1);
  // The array holds the items below NOS. Keep at least one entry so the
  // declaration stays legal when DEPTH is 2; that entry is never written.
  localparam int MEM_D = (DEPTH > 2) ? DEPTH - 2 : 1;
  localparam int AW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } op_e;

  op_e op;
  assign op = op_e'(OP);

  // Architectural state.
  logic [WIDTH-1:0] tos_q, nos_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] pop_data_q;
  logic             pop_valid_q;
  logic             overflow_q, underflow_q;
  logic [WIDTH-1:0] mem [MEM_D];

  // Next-state values.
  logic [WIDTH-1:0] tos_d, nos_d;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] pop_data_d;
  logic             pop_valid_d;
  logic             ovf_set, unf_set;

  // Push path shared by PUSH, DUP and OVER.
  logic             do_push;
  logic [WIDTH-1:0] push_val;

  // Array access. Writes spill the old NOS to the array; reads refill NOS.
  logic             mem_we;
  logic [AW-1:0]    mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0] mem_head;

  // Occupancy tests on the count before the operation.
  logic has1, has2, has3, full;
  assign has1 = (count_q != '0);
  assign has2 = (count_q >= CW'(2));
  assign has3 = (count_q >= CW'(3));
  assign full = (count_q == CW'(DEPTH));

  // With n items, array entries 0..n-3 are live; the head is entry n-3 and a
  // spilled NOS lands at entry n-2.
  assign mem_wr_addr = AW'(count_q - CW'(2));
  assign mem_rd_addr = AW'(count_q - CW'(3));
  assign mem_head    = has3 ? mem[mem_rd_addr] : '0;

`ifdef DATA_STACK_ARITH_EN
  // Single add/subtract unit, NOS op TOS, wrapping modulo 2^WIDTH.
  logic [WIDTH-1:0] alu_res;
  assign alu_res = (op == OP_SUB) ? (nos_q - tos_q) : (nos_q + tos_q);
`endif

  // Decode the operation, check its preconditions and form the next state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    tos_d       = tos_q;
    nos_d       = nos_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    do_push     = 1'b0;
    push_val    = '0;
    mem_we      = 1'b0;

    if (OP_VALID) begin
      case (op)
        OP_PUSH: begin
          if (full) ovf_set = 1'b1;
          else begin
            do_push  = 1'b1;
            push_val = PUSH_DATA;
          end
        end
        OP_POP: begin
          if (!has1) unf_set = 1'b1;
          else begin
            pop_valid_d = 1'b1;
            pop_data_d  = tos_q;
            // Popping the last item must leave the top reading zero.
            tos_d       = has2 ? nos_q : '0;
            nos_d       = mem_head;
            count_d     = count_q - CW'(1);
          end
        end
        OP_DUP: begin
          // Empty is checked first so that underflow wins over overflow.
          if (!has1)     unf_set = 1'b1;
          else if (full) ovf_set = 1'b1;
          else begin
            do_push  = 1'b1;
            push_val = tos_q;
          end
        end
        OP_SWAP: begin
          if (!has2) unf_set = 1'b1;
          else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
        OP_OVER: begin
          if (!has2)     unf_set = 1'b1;
          else if (full) ovf_set = 1'b1;
          else begin
            do_push  = 1'b1;
            push_val = nos_q;
          end
        end
`ifdef DATA_STACK_ARITH_EN
        OP_ADD, OP_SUB: begin
          if (!has2) unf_set = 1'b1;
          else begin
            tos_d   = alu_res;
            nos_d   = mem_head;
            count_d = count_q - CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end

    if (do_push) begin
      tos_d   = push_val;
      nos_d   = tos_q;
      count_d = count_q + CW'(1);
      // NOS only holds a live item (worth spilling) when n >= 2.
      mem_we  = has2;
    end
  end

  // State registers with synchronous reset; reset drops any concurrent op.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RST) begin
      tos_q       <= '0;
      nos_q       <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_q | ovf_set;
      underflow_q <= underflow_q | unf_set;
    end
  end

  // Deep storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: the array is deliberately not reset; entries above the count are
    // never read, so clearing them would only cost logic.
    if (mem_we && !RST) mem[mem_wr_addr] <= nos_q;
  end

  assign POP_DATA         = pop_data_q;
  assign POP_VALID        = pop_valid_q;
  assign STACK_TOP_ITEM   = tos_q;
  assign STACK_ITEM_COUNT = 32'(count_q);
  assign OVERFLOW         = overflow_q;
  assign UNDERFLOW        = underflow_q;

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: directed bench for data_stack with a queue-based reference
// model compared on every falling edge, plus literal expectations.
module tb_data_stack;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
`ifdef DATA_STACK_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         SWAP = 3'd4, OVER = 3'd5, ADD = 3'd6, SUB = 3'd7;

  logic             clk;
  logic             rst;
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top_item;
  logic [31:0]      item_count;
  logic             overflow;
  logic             underflow;

  data_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK              (clk),
    .RST              (rst),
    .OP_VALID         (op_valid),
    .OP               (op),
    .PUSH_DATA        (push_data),
    .POP_DATA         (pop_data),
    .POP_VALID        (pop_valid),
    .STACK_TOP_ITEM   (top_item),
    .STACK_ITEM_COUNT (item_count),
    .OVERFLOW         (overflow),
    .UNDERFLOW        (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: the back of the queue is the top of stack.
  logic [WIDTH-1:0] m_stk [$];
  logic [WIDTH-1:0] m_pop_data;
  bit               m_pop_valid;
  bit               m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    return (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
  endfunction

  task automatic model_reset();
    m_stk.delete();
    m_pop_data  = '0;
    m_pop_valid = 1'b0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
  endtask

  task automatic model_apply(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] d);
    int n;
    logic [WIDTH-1:0] a, b;
    n = m_stk.size();
    m_pop_valid = 1'b0;
    if (!v) return;
    case (o)
      PUSH: if (n == DEPTH) m_ovf = 1'b1; else m_stk.push_back(d);
      POP:  if (n == 0) m_unf = 1'b1;
            else begin m_pop_data = m_stk.pop_back(); m_pop_valid = 1'b1; end
      DUP:  if (n == 0) m_unf = 1'b1;
            else if (n == DEPTH) m_ovf = 1'b1;
            else m_stk.push_back(m_stk[n-1]);
      SWAP: if (n < 2) m_unf = 1'b1;
            else begin a = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = a; end
      OVER: if (n < 2) m_unf = 1'b1;
            else if (n == DEPTH) m_ovf = 1'b1;
            else m_stk.push_back(m_stk[n-2]);
      ADD, SUB: if (ARITH) begin
            if (n < 2) m_unf = 1'b1;
            else begin
              b = m_stk.pop_back();
              a = m_stk.pop_back();
              m_stk.push_back((o == ADD) ? a + b : a - b);
            end
          end
      default: ;
    endcase
  endtask

  // Issue one op across one rising edge, then return 1 ns after the edge.
  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d = '0, input logic v = 1'b1);
    op_valid  = v;
    op        = o;
    push_data = d;
    @(posedge clk);
    model_apply(v, o, d);
    #1;
    op_valid = 1'b0;
    op       = NOP;
  endtask

  // Hold reset for one edge, optionally with an op presented alongside it.
  task automatic do_reset(input logic v = 1'b0, input logic [2:0] o = NOP);
    rst      = 1'b1;
    op_valid = v;
    op       = o;
    @(posedge clk);
    model_reset();
    #1;
    rst      = 1'b0;
    op_valid = 1'b0;
    op       = NOP;
  endtask

  // Full output comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_top",       top_item,   m_top());
      check("cmp_count",     item_count, 32'(m_stk.size()));
      check("cmp_pop_valid", 32'(pop_valid), 32'(m_pop_valid));
      check("cmp_pop_data",  pop_data,   m_pop_data);
      check("cmp_overflow",  32'(overflow),  32'(m_ovf));
      check("cmp_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    op        = NOP;
    push_data = '0;
    model_reset();

    do_reset();
    cmp_en = 1'b1;
    check("reset_top",   top_item,   32'd0);
    check("reset_count", item_count, 32'd0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);

    // Two pushes, then ADD.
    do_op(PUSH, 32'd5);
    do_op(PUSH, 32'd7);
    check("push2_top",   top_item,   32'd7);
    check("push2_count", item_count, 32'd2);
    check("push2_flags", {30'd0, overflow, underflow}, 32'd0);
    do_op(ADD);
    check("add_top",   top_item,   ARITH ? 32'd12 : 32'd7);
    check("add_count", item_count, ARITH ? 32'd1 : 32'd2);

    // SUB, including the order of operands.
    do_reset();
    do_op(PUSH, 32'd7);
    do_op(PUSH, 32'd5);
    do_op(SUB);
    check("sub_top", top_item, ARITH ? 32'd2 : 32'd5);

    // SWAP then POP, with a single-cycle POP_VALID.
    do_reset();
    do_op(PUSH, 32'd1);
    do_op(PUSH, 32'd2);
    do_op(SWAP);
    do_op(POP);
    check("swap_pop_data",  pop_data, 32'd1);
    check("swap_pop_valid", 32'(pop_valid), 32'd1);
    do_op(NOP);
    check("swap_pop_pulse", 32'(pop_valid), 32'd0);
    check("swap_pop_top",   top_item,   32'd2);
    check("swap_pop_count", item_count, 32'd1);

    // Underflow from empty, then a PUSH with the flag staying set.
    do_reset();
    do_op(POP);
    check("unf_flag",      32'(underflow), 32'd1);
    check("unf_count",     item_count, 32'd0);
    check("unf_pop_valid", 32'(pop_valid), 32'd0);
    do_op(PUSH, 32'd3);
    check("unf_push_top",   top_item, 32'd3);
    check("unf_push_count", item_count, 32'd1);
    check("unf_sticky",     32'(underflow), 32'd1);

    // DUP on empty: underflow wins, overflow stays clear.
    do_reset();
    do_op(DUP);
    check("dup_empty", {30'd0, overflow, underflow}, 32'd1);

    // Fill past the top, then drain in LIFO order.
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) do_op(PUSH, 32'(i));
    check("full_count", item_count, 32'd16);
    check("full_top",   top_item,   32'd16);
    check("full_ovf",   32'(overflow), 32'd1);
    do_op(OVER);
    check("full_over_count", item_count, 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      do_op(POP);
      check("drain_data",  pop_data, 32'(DEPTH - i));
      check("drain_valid", 32'(pop_valid), 32'd1);
    end
    check("drain_count", item_count, 32'd0);
    check("drain_top",   top_item,   32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    check("drain_no_unf",     32'(underflow), 32'd0);

    // Mixed stream relying on the model, including wrap and a disabled op.
    do_reset();
    do_op(PUSH, 32'hFFFF_FFFF);
    do_op(PUSH, 32'd2);
    do_op(OVER);
    check("over_top", top_item, 32'hFFFF_FFFF);
    do_op(DUP);
    do_op(SWAP);
    do_op(POP, '0, 1'b0);
    check("disabled_count", item_count, 32'd4);
    do_op(ADD);
    do_op(PUSH, 32'd3);
    do_op(PUSH, 32'd4);
    do_op(SUB);
    do_op(POP);
    do_op(SWAP);
    do_op(ADD);
    do_op(SUB);
    do_op(POP);
    do_op(POP);
    do_op(POP);
    do_op(SWAP);
    do_op(NOP);

    // Reset wins over a concurrent OVER.
    do_reset();
    do_op(PUSH, 32'd9);
    do_reset(1'b1, OVER);
    check("rst_mid_top",   top_item,   32'd0);
    check("rst_mid_count", item_count, 32'd0);
    check("rst_mid_pop",   {pop_data[30:0], pop_valid}, 32'd0);
    check("rst_mid_flags", {30'd0, overflow, underflow}, 32'd0);

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
